// File: rtl/simplebmatinv_pkg.sv
// Shared constants, FSM state and 8x8 bit-matrix helpers
// for the GF(2) matrix inverter.
package simplebmatinv_pkg;

  localparam int N    = 8;
  localparam int COLW = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_e;

  // Row r is m[r]; column c of that row is m[r][c].
  typedef logic [N-1:0][N-1:0] mat_t;

  function automatic mat_t unpack(input logic [N*N-1:0] w);
    mat_t m;
    for (int r = 0; r < N; r++) m[r] = w[r*N +: N];
    return m;
  endfunction

  function automatic logic [N*N-1:0] pack(input mat_t m);
    logic [N*N-1:0] w;
    for (int r = 0; r < N; r++) w[r*N +: N] = m[r];
    return w;
  endfunction

  function automatic mat_t ident();
    mat_t m;
    m = '0;
    for (int r = 0; r < N; r++) m[r][r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/simplebmatinv_step.sv
// One Gauss-Jordan column step: pivot search, row swap, elimination.
// Ports: i_l/i_r working arrays, i_col column; o_l/o_r next arrays, o_no_pivot.
module simplebmatinv_step
  import simplebmatinv_pkg::*;
(
  input  mat_t            i_l,
  input  mat_t            i_r,
  input  logic [COLW-1:0] i_col,
  output mat_t            o_l,
  output mat_t            o_r,
  output logic            o_no_pivot
);

  logic [COLW-1:0] w_p;
  logic            w_found;
  mat_t            w_ls;
  mat_t            w_rs;

  // Scan downward so the lowest qualifying row wins.
  always_comb begin
    w_p     = '0;
    w_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i >= int'(i_col) && i_l[i][i_col]) begin
        w_p     = COLW'(i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_ls = i_l;
    w_rs = i_r;
    o_l  = i_l;
    o_r  = i_r;
    if (w_found) begin
      w_ls[w_p]   = i_l[i_col];
      w_ls[i_col] = i_l[w_p];
      w_rs[w_p]   = i_r[i_col];
      w_rs[i_col] = i_r[w_p];
      o_l = w_ls;
      o_r = w_rs;
      for (int i = 0; i < N; i++) begin
        if (i != int'(i_col) && w_ls[i][i_col]) begin
          o_l[i] = w_ls[i] ^ w_ls[i_col];
          o_r[i] = w_rs[i] ^ w_rs[i_col];
        end
      end
    end
  end

  assign o_no_pivot = !w_found;

endmodule

// File: rtl/simplebmatinv.sv
// Multi-cycle GF(2) 8x8 bit-matrix inverter, start/busy/done handshake.
// Ports: clock, reset (sync, active-high), start, rs1 in; rd, singular,
// busy, done out. SIMPLEBMATINV_EARLY_EXIT_EN: finish at first pivotless column.
module simplebmatinv
  import simplebmatinv_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [63:0]  rs1,
  output logic [63:0]  rd,
  output logic         singular,
  output logic         busy,
  output logic         done
);

`ifdef SIMPLEBMATINV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  state_e          r_state;
  mat_t            r_l;
  mat_t            r_r;
  logic [COLW-1:0] r_col;
  logic            r_sing_q;
  logic [63:0]     r_rd;
  logic            r_singular;
  logic            r_busy;
  logic            r_done;

  mat_t w_l;
  mat_t w_r;
  logic w_np;
  logic w_sing;
  logic w_last;

  simplebmatinv_step u_step (
    .i_l        (r_l),
    .i_r        (r_r),
    .i_col      (r_col),
    .o_l        (w_l),
    .o_r        (w_r),
    .o_no_pivot (w_np)
  );

  assign w_sing = r_sing_q | w_np;
  assign w_last = (r_col == COLW'(N - 1)) || (EARLY && w_np);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd       <= '0;
      r_singular <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_l      <= unpack(rs1);
        r_r      <= ident();
        r_col    <= '0;
        r_sing_q <= 1'b0;
        r_state  <= S_RUN;
        r_busy   <= 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: ;
          S_RUN: begin
            r_l      <= w_l;
            r_r      <= w_r;
            r_sing_q <= w_sing;
            r_col    <= r_col + COLW'(1);
            if (w_last) begin
              r_state    <= S_FIN;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_rd       <= w_sing ? 64'd0 : pack(w_r);
              r_singular <= w_sing;
            end
          end
          S_FIN: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rd       = r_rd;
  assign singular = r_singular;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
